// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Register file with a per-register busy (pending write) scoreboard.
//   Reads are combinational on NRP independent ports. Register 0 always
//   reads as zero and is never marked busy. An issued instruction marks
//   its destination busy, and its writeback clears the mark. When an issue
//   and a writeback hit the same register in one cycle, the busy mark
//   stays set, because the newer producer is still outstanding.
//
//   Optional feature macro: RF_BYPASS_EN
//     When defined, a read that matches the writeback address in the same
//     cycle returns wdata and reports the register as not busy. The
//     exception is when the same register is also being re-issued in that
//     cycle.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   raddr     NRP read addresses, port p at [p*RFW +: RFW]
//   rdata     NRP read data,      port p at [p*DW  +: DW]
//   rbusy     per-port busy flag of the addressed register
//   we/waddr/wdata   writeback
//   iss_v/iss_rd     issue strobe and destination register
//   busy_cnt  population count of the busy vector
module rf_scoreboard #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int NRP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRP*RFW-1:0] raddr,
  output logic [NRP*DW-1:0]  rdata,
  output logic [NRP-1:0]     rbusy,
  input  logic               we,
  input  logic [RFW-1:0]     waddr,
  input  logic [DW-1:0]      wdata,
  input  logic               iss_v,
  input  logic [RFW-1:0]     iss_rd,
  output logic [RFW:0]       busy_cnt
);

  localparam int NREG = 1 << RFW;

  logic [DW-1:0]   regs_reg [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [RFW:0]    cnt_next;
  logic            wr_hit;
  logic            iss_hit;

  assign wr_hit  = we && (waddr != '0);
  assign iss_hit = iss_v && (iss_rd != '0);

  // Clear first, then set, so a same-cycle issue wins over the writeback.
  always_comb begin
    busy_next = busy_reg;
    if (wr_hit)
      busy_next[waddr] = 1'b0;
    if (iss_hit)
      busy_next[iss_rd] = 1'b1;
  end

  // busy_cnt is registered from the next-state vector. This keeps it in
  // step with the busy bits on the same edge.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++)
      cnt_next = cnt_next + (RFW+1)'(busy_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_reg[i] <= '0;
      busy_reg <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit)
        regs_reg[waddr] <= wdata;
      busy_reg <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [RFW-1:0] ra;
    logic [DW-1:0]  rd;
    logic           rb;

    assign ra = raddr[gi*RFW +: RFW];

    always_comb begin
      rd = regs_reg[ra];
      rb = busy_reg[ra];
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed during reset so that every port reads
      // zero while rst is high.
      else if (wr_hit && !rst && (ra == waddr)) begin
        rd = wdata;
        rb = iss_v && (iss_rd == waddr);
      end
`endif
    end

    assign rdata[gi*DW +: DW] = rd;
    assign rbusy[gi]          = rb;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

  localparam int RFW = 5;
  localparam int DW  = 32;
  localparam int NRP = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NRP*RFW-1:0] raddr = '0;
  logic [NRP*DW-1:0]  rdata;
  logic [NRP-1:0]     rbusy;
  logic               we = 1'b0;
  logic [RFW-1:0]     waddr = '0;
  logic [DW-1:0]      wdata = '0;
  logic               iss_v = 1'b0;
  logic [RFW-1:0]     iss_rd = '0;
  logic [RFW:0]       busy_cnt;

  rf_scoreboard #(.RFW(RFW), .DW(DW), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_v(iss_v), .iss_rd(iss_rd),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Kinds of observation the monitor can compare.
  localparam int K_RD0 = 0, K_RD1 = 1, K_RB0 = 2, K_RB1 = 3, K_CNT = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on the falling edge, pop every expectation tagged for this
  // cycle and compare it against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD0:   act = rdata[0*DW +: DW];
        K_RD1:   act = rdata[1*DW +: DW];
        K_RB0:   act = {31'd0, rbusy[0]};
        K_RB1:   act = {31'd0, rbusy[1]};
        default: act = {26'd0, busy_cnt};
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [RFW-1:0] wa,
                       input logic [DW-1:0] wd, input logic iv, input logic [RFW-1:0] ir,
                       input logic [RFW-1:0] ra0, input logic [RFW-1:0] ra1);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd; iss_v = iv; iss_rd = ir;
    raddr = {ra1, ra0};
    $display("cyc %0d: rst=%0b we=%0b waddr=%0d wdata=0x%08h iss=%0b rd=%0d ra0=%0d ra1=%0d",
             cyc, r, w, wa, wd, iv, ir, ra0, ra1);
  endtask

  task automatic expect_v(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  localparam logic [RFW-1:0] Z = '0;

  initial begin
    // While reset is held, we and iss_v are ignored and all outputs read zero.
    drive(1, 1, 5'd6, 32'hCAFE0006, 1, 5'd6, 5'd6, 5'd0);
    expect_v(K_RD0, 0, "rst_rdata0");
    expect_v(K_RB0, 0, "rst_rbusy0");
    expect_v(K_CNT, 0, "rst_cnt");
    drive(0, 0, Z, 0, 0, Z, 5'd6, 5'd6);
    expect_v(K_RD0, 0, "post_rst_r6");
    expect_v(K_CNT, 0, "post_rst_cnt");

    // Every address on both ports reads zero and not busy after reset.
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, Z, 0, 0, Z, 5'(a), 5'(31 - a));
      expect_v(K_RD0, 0, $sformatf("clr_rd0_a%0d", a));
      expect_v(K_RD1, 0, $sformatf("clr_rd1_a%0d", 31 - a));
      expect_v(K_RB0, 0, $sformatf("clr_rb0_a%0d", a));
      expect_v(K_RB1, 0, $sformatf("clr_rb1_a%0d", 31 - a));
      expect_v(K_CNT, 0, $sformatf("clr_cnt_a%0d", a));
    end

    // A write to register 0 is discarded; a write to r5 lands the next cycle.
    drive(0, 1, 5'd0, 32'hDEADBEEF, 0, Z, 5'd0, 5'd0);
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, Z, 5'd0, 5'd5);
    expect_v(K_RD0, 0, "r0_discard");
`ifdef RF_BYPASS_EN
    expect_v(K_RD1, 32'hDEADBEEF, "r5_same_cycle_bypass");
`else
    expect_v(K_RD1, 0, "r5_same_cycle_old");
`endif
    drive(0, 0, Z, 0, 0, Z, 5'd5, 5'd0);
    expect_v(K_RD0, 32'hDEADBEEF, "r5_written");
    expect_v(K_CNT, 0, "plain_write_cnt");

    // Issue r3 then r7, then write back r3.
    drive(0, 0, Z, 0, 1, 5'd3, 5'd3, 5'd7);
    drive(0, 0, Z, 0, 1, 5'd7, 5'd3, 5'd7);
    expect_v(K_CNT, 1, "cnt_after_iss3");
    expect_v(K_RB0, 1, "rbusy_r3_set");
    expect_v(K_RB1, 0, "rbusy_r7_not_yet");
    drive(0, 1, 5'd3, 32'h11, 0, Z, 5'd3, 5'd7);
    expect_v(K_CNT, 2, "cnt_after_iss7");
`ifdef RF_BYPASS_EN
    expect_v(K_RB0, 0, "rbusy_r3_bypass");
`else
    expect_v(K_RB0, 1, "rbusy_r3_prewb");
`endif
    expect_v(K_RB1, 1, "rbusy_r7_set");
    drive(0, 0, Z, 0, 1, 5'd7, 5'd3, 5'd7);
    expect_v(K_CNT, 1, "cnt_after_wb3");
    expect_v(K_RB0, 0, "rbusy_r3_clr");
    expect_v(K_RB1, 1, "rbusy_r7_still");
    expect_v(K_RD0, 32'h11, "r3_data");

    // Re-issue of busy r7 and an issue to r0 both leave the count unchanged.
    drive(0, 0, Z, 0, 1, 5'd0, 5'd0, 5'd7);
    expect_v(K_CNT, 1, "cnt_reissue_r7");
    drive(0, 0, Z, 0, 1, 5'd9, 5'd0, 5'd9);
    expect_v(K_CNT, 1, "cnt_iss_r0");
    expect_v(K_RB0, 0, "rbusy_r0_never");

    // Same-cycle issue and writeback of busy r9: busy stays set, data updates.
    drive(0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd7);
    expect_v(K_CNT, 2, "cnt_r9_busy");
    drive(0, 0, Z, 0, 0, Z, 5'd9, 5'd9);
    expect_v(K_CNT, 2, "cnt_iss_wins");
    expect_v(K_RB0, 1, "rbusy_r9_kept");
    expect_v(K_RD0, 32'h99, "r9_data");

    // Same-cycle read of a register being written.
    drive(0, 1, 5'd4, 32'h00001234, 0, Z, 5'd0, 5'd4);
    drive(0, 1, 5'd4, 32'hA5A5A5A5, 0, Z, 5'd0, 5'd4);
`ifdef RF_BYPASS_EN
    expect_v(K_RD1, 32'hA5A5A5A5, "r4_bypass");
`else
    expect_v(K_RD1, 32'h00001234, "r4_old_value");
`endif
    drive(0, 1, 5'd31, 32'hFFFF0001, 0, Z, 5'd31, 5'd4);
    expect_v(K_RD1, 32'hA5A5A5A5, "r4_new_value");
    drive(0, 0, Z, 0, 0, Z, 5'd31, 5'd4);
    expect_v(K_RD0, 32'hFFFF0001, "r31_top_reg");

    // r2 = 0x55 and busy, then reset mid-cycle.
    drive(0, 1, 5'd2, 32'h55, 0, Z, 5'd2, 5'd9);
    drive(0, 0, Z, 0, 1, 5'd2, 5'd2, 5'd9);
    drive(0, 0, Z, 0, 0, Z, 5'd2, 5'd9);
    expect_v(K_CNT, 3, "cnt_r2_busy");
    expect_v(K_RD0, 32'h55, "r2_data");
    expect_v(K_RB0, 1, "rbusy_r2");
    drive(1, 1, 5'd2, 32'h77, 1, 5'd5, 5'd2, 5'd9);
    expect_v(K_RD0, 0, "midrst_rd0");
    expect_v(K_RB0, 0, "midrst_rb0");
    expect_v(K_RB1, 0, "midrst_rb1");
    expect_v(K_CNT, 0, "midrst_cnt");
    drive(1, 0, Z, 0, 0, Z, 5'd2, 5'd9);
    drive(0, 0, Z, 0, 1, 5'd1, 5'd2, 5'd9);
    expect_v(K_RD0, 0, "postrst_r2");
    expect_v(K_RB1, 0, "postrst_rb9");
    expect_v(K_CNT, 0, "postrst_cnt");
    drive(0, 0, Z, 0, 0, Z, 5'd1, 5'd5);
    expect_v(K_CNT, 1, "resume_cnt");
    expect_v(K_RB0, 1, "resume_rb1");
    expect_v(K_RB1, 0, "resume_rb5");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter RFW, default 5, register address width (2**RFW registers).
REQ-002 SHALL have parameter DW, default 32, register data width.
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port raddr  input  NRP*RFW  read addresses; port p occupies bits [p*RFW +: RFW].
REQ-007 SHALL have port rdata  output  NRP*DW  read data; port p occupies bits [p*DW +: DW].
REQ-008 SHALL have port rbusy  output  NRP  per-read-port flag: the addressed register has a pending write.
REQ-009 SHALL have port we  input  1  writeback enable.
REQ-010 SHALL have port waddr  input  RFW  writeback register address.
REQ-011 SHALL have port wdata  input  DW  writeback data.
REQ-012 SHALL have port iss_v  input  1  issue strobe: an instruction that will write iss_rd has entered the pipe.
REQ-013 SHALL have port iss_rd  input  RFW  destination register of the issued instruction.
REQ-014 SHALL have port busy_cnt  output  RFW+1  number of registers currently marked busy.

Function
REQ-015 SHALL hold 2**RFW registers of DW bits and one busy bit per register.
REQ-016 SHALL perform reads combinationally (zero latency) on every port independently.
REQ-017 SHALL return 0 on rdata and 0 on rbusy for any port addressing register 0.
REQ-018 SHALL write wdata to register waddr on the rising clk edge when we=1 and waddr!=0; writes to register 0 are discarded.
REQ-019 SHALL set busy[iss_rd] on the rising clk edge when iss_v=1 and iss_rd!=0; issues to register 0 are ignored.
REQ-020 SHALL clear busy[waddr] on the rising clk edge when we=1 and waddr!=0.
REQ-021 SHALL leave busy[r] set when set and clear target the same r in the same cycle (issue wins, newer producer pending).
REQ-022 SHALL update busy_cnt on the same edge as the busy bits, equal to the population count of the busy vector after that edge.
REQ-023 SHALL accept a clear of a non-busy register as a plain write, with busy and busy_cnt unchanged.
REQ-024 SHALL accept re-issue to an already busy register with busy_cnt unchanged.
REQ-025 SHALL make rbusy[p] equal to busy[raddr_p] from the registered busy vector, subject to REQ-017 and REQ-031.

Reset
REQ-026 SHALL, while rst=1, asynchronously force every register to 0, every busy bit to 0 and busy_cnt to 0.
REQ-027 SHALL therefore drive rdata=0 and rbusy=0 on all ports during reset, for any raddr.
REQ-028 SHALL ignore we and iss_v during reset; a reset asserted mid-operation discards all pending state.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL support macro RF_BYPASS_EN selecting same-cycle writeback forwarding.
REQ-031 SHALL, with RF_BYPASS_EN defined, drive rdata[p]=wdata when we=1 and raddr_p==waddr!=0, and drive rbusy[p]=0 on that port unless iss_v=1 with iss_rd==waddr that cycle.
REQ-032 SHALL, without RF_BYPASS_EN, return the stored pre-edge value and registered busy bit during a same-cycle write to that address.

Verification
REQ-033 SHALL cover: reset, then read all 32 addresses on both ports -> rdata=0, rbusy=0, busy_cnt=0.
REQ-034 SHALL cover: we=1 waddr=0 wdata=0xDEADBEEF, next cycle raddr0=0 -> rdata0=0; waddr=5 same data -> next cycle rdata0=0xDEADBEEF at raddr0=5.
REQ-035 SHALL cover: iss_v rd=3, iss_v rd=7, then we waddr=3 wdata=0x11 -> busy_cnt 1,2,1; rbusy for r3=0, for r7=1.
REQ-036 SHALL cover: same cycle iss_v rd=9 and we waddr=9 with r9 busy -> r9 stays busy, busy_cnt unchanged, r9 data updated.
REQ-037 SHALL cover: we waddr=4 wdata=0xA5A5A5A5 with raddr1=4 same cycle -> rdata1=0xA5A5A5A5 with RF_BYPASS_EN, old r4 value without.
REQ-038 SHALL cover: r2 busy and r2=0x55, assert rst mid-cycle between edges -> rdata=0, busy_cnt=0 immediately, before the next edge.
